p_accum_out_stage: RTL
======================

P_ACCUM_OUT_STAGE -- requirements
Module: p_accum_out_stage

Interface
REQ-001 SHALL have parameter PREG, default 1: 1 = p output registered, 0 = p output combinational.
REQ-002 SHALL have parameter CARRYOUTREG, default 1: 1 = carryout registered, 0 = carryout combinational.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port clken, input, 1: clock enable for the P and carry-out registers.
REQ-006 SHALL have port m, input, 36: multiplier product.
REQ-007 SHALL have port dab, input, 48: concatenated D:A:B operand.
REQ-008 SHALL have port c, input, 48: C operand.
REQ-009 SHALL have port pcin, input, 48: cascade input from the upstream slice.
REQ-010 SHALL have port opmode, input, 8: [1:0] X select, [3:2] Z select, [7] subtract; bits [6:4] ignored.
REQ-011 SHALL have port carry_in, input, 1: post-adder carry input.
REQ-012 SHALL have port p, output, 48: result.
REQ-013 SHALL have port pcout, output, 48: cascade output, always identical to p.
REQ-014 SHALL have port carryout, output, 1: post-adder carry/borrow bit.
REQ-015 SHALL have port carryoutf, output, 1: fabric copy, always identical to carryout.

Function
REQ-016 SHALL select X per opmode[1:0]: 0 -> 48'h0; 1 -> m zero-extended to 48 bits; 2 -> internal P register; 3 -> dab.
REQ-017 SHALL select Z per opmode[3:2]: 0 -> 48'h0; 1 -> pcin; 2 -> internal P register; 3 -> c.
REQ-018 SHALL compute a 49-bit result R: opmode[7]=0 -> {0,Z} + {0,X} + carry_in; opmode[7]=1 -> {0,Z} - ({0,X} + carry_in), modulo 2^49.
REQ-019 SHALL treat R[47:0] as the next P value and R[48] as the next carry-out value.
REQ-020 SHALL load the internal P register with R[47:0] and the internal carry register with R[48] on a rising edge when clken=1 and reset=0.
REQ-021 SHALL hold both internal registers when clken=0 and reset=0.
REQ-022 SHALL update the internal P and carry registers regardless of PREG and CARRYOUTREG; parameters affect only the outputs.
REQ-023 SHALL source P feedback (X=2 or Z=2) from the internal P register in all parameter settings.
REQ-024 SHALL drive p from the internal P register when PREG=1, giving one cycle of latency; SHALL drive p from R[47:0] when PREG=0, giving zero latency.
REQ-025 SHALL drive carryout from the internal carry register when CARRYOUTREG=1; SHALL drive it from R[48] when CARRYOUTREG=0.
REQ-026 SHALL wrap overflow silently modulo 2^48 with no saturation.
REQ-027 SHALL signal all overflow only through R[48].
REQ-028 SHALL take opmode changes effect on the first edge at which they are sampled, with no extra pipeline stage.

Reset
REQ-029 SHALL clear the internal P register to 48'h0 and the internal carry register to 0 on a rising edge with reset=1.
REQ-030 SHALL give reset priority over clken.
REQ-031 SHALL have registered p, pcout, carryout and carryoutf read 0 on the cycle after a reset edge.
REQ-032 SHALL clear state when reset is asserted mid-accumulation, including when clken=0.
REQ-033 SHALL restart accumulation from 0 on the first enabled edge after reset deasserts.
REQ-034 SHALL have combinational outputs (PREG=0 or CARRYOUTREG=0) follow the current inputs during reset, with P feedback reading 0.

Verification
REQ-035 SHALL cover power-up: reset=1 for one edge -> p=0, carryout=0, pcout=0.
REQ-036 SHALL cover single add: opmode=8'h01, m=5, carry_in=1, clken=1 -> p=6 one cycle later.
REQ-037 SHALL cover accumulate: opmode=8'h09, m=3, four enabled edges -> p=3,6,9,12; then clken=0 for 3 edges -> p holds 12.
REQ-038 SHALL cover wrap: opmode=8'h0D, c=48'hFFFF_FFFF_FFFF, m=1 -> p=0, carryout=1.
REQ-039 SHALL cover subtract: opmode=8'h8D, c=10, m=3 -> p=7, carryout=0; then c=2, m=3 -> p=48'hFFFF_FFFF_FFFF, carryout=1.
REQ-040 SHALL cover mid-accumulation reset: reset=1 with clken=0 after p=12 -> p=0 next cycle.
REQ-041 SHALL cover PREG=0 and CARRYOUTREG=0: p and carryout track R in the same cycle.

Source files
------------

// File: rtl/p_accum_out_stage.sv
// Post-adder / accumulator output stage: selects X and Z operands, adds or subtracts
// them with a carry-in, and presents the 48-bit result and carry either registered or direct.
module p_accum_out_stage #(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clken,
    input  logic [35:0] m,
    input  logic [47:0] dab,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic [7:0]  opmode,
    input  logic        carry_in,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        carryoutf
);

    logic [47:0] p_q;
    logic [47:0] p_d;
    logic        cy_q;
    logic        cy_d;
    logic [47:0] p_fb;
    logic [47:0] x_sel;
    logic [47:0] z_sel;
    logic [48:0] addend;
    logic [48:0] r;
    logic        unused_opmode_bits;

    assign unused_opmode_bits = ^opmode[6:4];

    // While reset is held the accumulator is treated as already cleared, so the
    // direct outputs never expose the stale pre-reset value.
    assign p_fb = reset ? 48'h0 : p_q;

    always_comb begin
        x_sel = 48'h0;
        case (opmode[1:0])
            2'd1:    x_sel = {12'h0, m};
            2'd2:    x_sel = p_fb;
            2'd3:    x_sel = dab;
            default: x_sel = 48'h0;
        endcase
    end

    always_comb begin
        z_sel = 48'h0;
        case (opmode[3:2])
            2'd1:    z_sel = pcin;
            2'd2:    z_sel = p_fb;
            2'd3:    z_sel = c;
            default: z_sel = 48'h0;
        endcase
    end

    // Subtract folds carry_in into the subtrahend; R[48] then reads as a borrow.
    always_comb begin
        addend = {1'b0, x_sel} + {48'h0, carry_in};
        if (opmode[7]) begin
            r = {1'b0, z_sel} - addend;
        end else begin
            r = {1'b0, z_sel} + addend;
        end
        p_d  = r[47:0];
        cy_d = r[48];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q  <= 48'h0;
            cy_q <= 1'b0;
        end else if (clken) begin
            p_q  <= p_d;
            cy_q <= cy_d;
        end
    end

    generate
        if (PREG != 0) begin : g_p_reg
            assign p = p_q;
        end else begin : g_p_comb
            assign p = p_d;
        end

        if (CARRYOUTREG != 0) begin : g_cy_reg
            assign carryout = cy_q;
        end else begin : g_cy_comb
            assign carryout = cy_d;
        end
    endgenerate

    assign pcout     = p;
    assign carryoutf = carryout;

endmodule
